// File: rtl/control_pkg.sv
`default_nettype none
// ---- control_pkg : state, code points and decode bundle for the nic8 sequencer | rev 1.0 ----
package control_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] SRC_A   = 3'd0;
  localparam logic [2:0] SRC_X   = 3'd1;
  localparam logic [2:0] SRC_ADD = 3'd2;
  localparam logic [2:0] SRC_SUB = 3'd3;
  localparam logic [2:0] SRC_IMM = 3'd4;

  localparam logic [2:0] DST_A    = 3'd0;
  localparam logic [2:0] DST_B    = 3'd1;
  localparam logic [2:0] DST_X    = 3'd2;
  localparam logic [2:0] DST_Q    = 3'd3;
  localparam logic [2:0] DST_PC   = 3'd4;
  localparam logic [2:0] DST_PC_Z = 3'd5;
  localparam logic [2:0] DST_PC_C = 3'd6;
  localparam logic [2:0] DST_NONE = 3'd7;

  typedef struct packed {
    logic trig_a;
    logic trig_b;
    logic trig_x;
    logic trig_q;
    logic assert_bar_a;
    logic assert_bar_x;
    logic assert_bar_alu;
    logic alu_sub;
    logic drive_imm;
    logic pc_load;
    logic pc_inc;
    logic flag_latch;
  } decode_t;

  // Halt is src=7,dst=7 regardless of the two ignored low bits.
  function automatic logic IS_HALT(input logic [7:0] b);
    return (b | 8'h03) == 8'hFF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ---- control_sequencer_if : ROM, strobe and flag signals between sequencer and datapath | rev 1.0 ----
interface control_sequencer_if;
  logic [7:0] romAddr;
  logic [7:0] romData;
  logic       triggerA;
  logic       triggerB;
  logic       triggerX;
  logic       triggerQ;
  logic       assertBarA;
  logic       assertBarX;
  logic       assertBarAlu;
  logic       aluSub;
  logic       zeroIn;
  logic       carryIn;
  logic       halted;
  logic [7:0] ir;

  modport master (
    output romAddr,
    input  romData,
    output triggerA, triggerB, triggerX, triggerQ,
    output assertBarA, assertBarX, assertBarAlu, aluSub,
    input  zeroIn, carryIn,
    output halted, ir
  );

  modport slave (
    input  romAddr,
    output romData,
    input  triggerA, triggerB, triggerX, triggerQ,
    input  assertBarA, assertBarX, assertBarAlu, aluSub,
    output zeroIn, carryIn,
    input  halted, ir
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_instr_decode.sv
`default_nettype none
// ---- instr_decode : combinational strobe decode from state, opcode fields and flags | rev 1.0 ----
module instr_decode
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zf,
  input  logic       cf,
  output decode_t    dec
);

  logic [2:0] src;
  logic [2:0] dst;
  logic       src_ok;

  assign src    = op[5:3];
  assign dst    = op[2:0];
  assign src_ok = (src <= SRC_IMM);

  always_comb begin
    dec                = '0;
    dec.assert_bar_a   = 1'b1;
    dec.assert_bar_x   = 1'b1;
    dec.assert_bar_alu = 1'b1;

    // Reserved sources decode to a pure two-cycle NOP: no driver, no load.
    if (state == EXEC && src_ok) begin
      case (src)
        SRC_A:   dec.assert_bar_a = 1'b0;
        SRC_X:   dec.assert_bar_x = 1'b0;
        SRC_ADD: begin
          dec.assert_bar_alu = 1'b0;
          dec.flag_latch     = 1'b1;
        end
        SRC_SUB: begin
          dec.assert_bar_alu = 1'b0;
          dec.alu_sub        = 1'b1;
          dec.flag_latch     = 1'b1;
        end
        SRC_IMM: begin
          dec.drive_imm = 1'b1;
          dec.pc_inc    = 1'b1;
        end
        default: ;
      endcase

      case (dst)
        DST_A:    dec.trig_a  = 1'b1;
        DST_B:    dec.trig_b  = 1'b1;
        DST_X:    dec.trig_x  = 1'b1;
        DST_Q:    dec.trig_q  = 1'b1;
        DST_PC:   dec.pc_load = 1'b1;
        DST_PC_Z: dec.pc_load = zf;
        DST_PC_C: dec.pc_load = cf;
        DST_NONE: ;
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ---- control_sequencer : two-clock fetch/execute sequencer holding pc, ir, flags | rev 1.0 ----
module control_sequencer
  import control_pkg::*;
(
  input  wire                        clk,
  input  wire                        resetBar,
  inout  wire [7:0]                  dbus,
  control_sequencer_if.master        bus
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       zf_q, zf_d;
  logic       cf_q, cf_d;
  decode_t    dec;

  instr_decode u_decode (
    .state (state_q),
    .op    (ir_q[7:2]),
    .zf    (zf_q),
    .cf    (cf_q),
    .dec   (dec)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    cf_d    = cf_q;

    case (state_q)
      FETCH: begin
        ir_d    = bus.romData;
        pc_d    = pc_q + 8'd1;
        state_d = IS_HALT(bus.romData) ? HALT : EXEC;
      end
      EXEC: begin
        // A taken jump wins over the immediate-skip increment.
        if (dec.pc_load) begin
          pc_d = dbus;
        end else if (dec.pc_inc) begin
          pc_d = pc_q + 8'd1;
        end
        if (dec.flag_latch) begin
          zf_d = bus.zeroIn;
          cf_d = bus.carryIn;
        end
        state_d = FETCH;
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q <= FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  assign dbus = dec.drive_imm ? bus.romData : 8'hzz;

  assign bus.romAddr      = pc_q;
  assign bus.ir           = ir_q;
  assign bus.halted       = (state_q == HALT);
  assign bus.triggerA     = dec.trig_a;
  assign bus.triggerB     = dec.trig_b;
  assign bus.triggerX     = dec.trig_x;
  assign bus.triggerQ     = dec.trig_q;
  assign bus.assertBarA   = dec.assert_bar_a;
  assign bus.assertBarX   = dec.assert_bar_x;
  assign bus.assertBarAlu = dec.assert_bar_alu;
  assign bus.aluSub       = dec.alu_sub;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ---- tb_control_sequencer : vector table plus directed sequences against a small A/B/X/Q/ALU/ROM model | rev 1.0 ----
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       resetBar = 1'b0;
  wire  [7:0] dbus;
  logic [7:0] rom [256];
  logic [7:0] reg_a, reg_b, reg_x, reg_q;
  logic [8:0] alu_res;
  int         n_cmp = 0;
  int         n_bad = 0;

  control_sequencer_if bus();

  control_sequencer dut (
    .clk      (clk),
    .resetBar (resetBar),
    .dbus     (dbus),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Environment: ROM, register file and ALU sharing dbus with the sequencer.
  assign bus.romData = rom[bus.romAddr];
  assign alu_res     = bus.aluSub ? ({1'b0, reg_a} + {1'b0, ~reg_b} + 9'd1)
                                  : ({1'b0, reg_a} + {1'b0, reg_b});
  assign bus.zeroIn  = (alu_res[7:0] == 8'h00);
  assign bus.carryIn = alu_res[8];
  assign dbus = !bus.assertBarA   ? reg_a :
                !bus.assertBarX   ? reg_x :
                !bus.assertBarAlu ? alu_res[7:0] : 8'hzz;

  always @(posedge clk) begin
    if (!resetBar) begin
      reg_a <= 8'h11;
      reg_b <= 8'h05;
      reg_x <= 8'h22;
      reg_q <= 8'h00;
    end else begin
      if (bus.triggerA) reg_a <= dbus;
      if (bus.triggerB) reg_b <= dbus;
      if (bus.triggerX) reg_x <= dbus;
      if (bus.triggerQ) reg_q <= dbus;
    end
  end

  function automatic logic [7:0] strobes();
    return {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ,
            bus.assertBarA, bus.assertBarX, bus.assertBarAlu, bus.aluSub};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic rom_fill();
    for (int i = 0; i < 256; i++) rom[i] = 8'hFC;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    resetBar = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cyc, output int sub_cyc, output int alu_cyc);
    sub_cyc = 0;
    alu_cyc = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (bus.aluSub) sub_cyc++;
      if (!bus.assertBarAlu) alu_cyc++;
      if (bus.halted) break;
    end
    check("halt_reached", {31'd0, bus.halted}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] opnd;
    logic [7:0] strb;
    logic       chk_bus;
    logic [7:0] bus_v;
    logic [7:0] next_pc;
  } vec_t;

  vec_t vecs[14];
  int   sub_c, alu_c;

  initial begin
    // strb = {trigA, trigB, trigX, trigQ, abarA, abarX, abarAlu, aluSub}
    vecs[0]  = '{8'h00, 8'hFC, 8'b1000_0110, 1'b1, 8'h11, 8'h01}; // A -> A
    vecs[1]  = '{8'h24, 8'hFC, 8'b0100_1010, 1'b1, 8'h22, 8'h01}; // X -> B
    vecs[2]  = '{8'h48, 8'hFC, 8'b0010_1100, 1'b1, 8'h16, 8'h01}; // add -> X
    vecs[3]  = '{8'h6C, 8'hFC, 8'b0001_1101, 1'b1, 8'h0C, 8'h01}; // sub -> Q
    vecs[4]  = '{8'h1C, 8'hFC, 8'b0000_0110, 1'b1, 8'h11, 8'h01}; // A -> none
    vecs[5]  = '{8'h80, 8'h5A, 8'b1000_1110, 1'b1, 8'h5A, 8'h02}; // imm -> A
    vecs[6]  = '{8'h90, 8'h40, 8'b0000_1110, 1'b1, 8'h40, 8'h40}; // imm -> pc
    vecs[7]  = '{8'h94, 8'h40, 8'b0000_1110, 1'b1, 8'h40, 8'h02}; // imm -> pc if Z, not taken
    vecs[8]  = '{8'h98, 8'h40, 8'b0000_1110, 1'b1, 8'h40, 8'h02}; // imm -> pc if C, not taken
    vecs[9]  = '{8'h10, 8'hFC, 8'b0000_0110, 1'b1, 8'h11, 8'h11}; // A -> pc
    vecs[10] = '{8'hA0, 8'hFC, 8'b0000_1110, 1'b0, 8'h00, 8'h01}; // reserved src 5
    vecs[11] = '{8'hC8, 8'hFC, 8'b0000_1110, 1'b0, 8'h00, 8'h01}; // reserved src 6
    vecs[12] = '{8'hE0, 8'hFC, 8'b0000_1110, 1'b0, 8'h00, 8'h01}; // src 7, not halt
    vecs[13] = '{8'h84, 8'h99, 8'b0100_1110, 1'b1, 8'h99, 8'h02}; // imm -> B

    // Reset values while reset is held.
    rom_fill();
    #12;
    check("rst_strobes", {24'd0, strobes()}, 32'h0E);
    check("rst_romaddr", {24'd0, bus.romAddr}, 32'h00);
    check("rst_ir", {24'd0, bus.ir}, 32'h00);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);

    foreach (vecs[i]) begin
      rom_fill();
      rom[0] = vecs[i].op;
      rom[1] = vecs[i].opnd;
      do_reset();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_strobes", i), {24'd0, strobes()}, {24'd0, vecs[i].strb});
      check($sformatf("v%0d_ir", i), {24'd0, bus.ir}, {24'd0, vecs[i].op});
      if (vecs[i].chk_bus) check($sformatf("v%0d_dbus", i), {24'd0, dbus}, {24'd0, vecs[i].bus_v});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_next_pc", i), {24'd0, bus.romAddr}, {24'd0, vecs[i].next_pc});
    end

    // IMM -> A then halt.
    rom_fill();
    rom[0] = 8'h80; rom[1] = 8'h2A; rom[2] = 8'hFC;
    do_reset();
    check("t1_fetch_trigA", {31'd0, bus.triggerA}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_exec_trigA", {31'd0, bus.triggerA}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("t1_after_trigA", {31'd0, bus.triggerA}, 32'd0);
    check("t1_reg_a", {24'd0, reg_a}, 32'h2A);
    @(posedge clk); @(negedge clk);
    check("t1_halted", {31'd0, bus.halted}, 32'd1);
    check("t1_romaddr", {24'd0, bus.romAddr}, 32'h03);
    repeat (3) @(negedge clk);
    check("t1_romaddr_frozen", {24'd0, bus.romAddr}, 32'h03);
    check("t1_halt_strobes", {24'd0, strobes()}, 32'h0E);

    // B=5, A=3, Q=A-B; flags both clear so both conditional jumps fall through.
    rom_fill();
    rom[0] = 8'h84; rom[1] = 8'h05; rom[2] = 8'h80; rom[3] = 8'h03;
    rom[4] = 8'h6C; rom[5] = 8'h94; rom[6] = 8'h40; rom[7] = 8'h98; rom[8] = 8'h60;
    rom[9] = 8'hFC;
    do_reset();
    run_until_halt(40, sub_c, alu_c);
    check("t2_reg_q", {24'd0, reg_q}, 32'hFE);
    check("t2_sub_cycles", sub_c, 32'd1);
    check("t2_alu_cycles", alu_c, 32'd1);
    check("t2_final_pc", {24'd0, bus.romAddr}, 32'h0A);

    // B=3, A=3, Q=A-B sets Z and C, so both conditional jumps are taken.
    rom_fill();
    rom[0] = 8'h84; rom[1] = 8'h03; rom[2] = 8'h80; rom[3] = 8'h03;
    rom[4] = 8'h6C; rom[5] = 8'h94; rom[6] = 8'h40;
    rom[8'h40] = 8'h98; rom[8'h41] = 8'h50;
    do_reset();
    repeat (4) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t3_jz_taken", {24'd0, bus.romAddr}, 32'h05);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("t3_jz_target", {24'd0, bus.romAddr}, 32'h40);
    run_until_halt(20, sub_c, alu_c);
    check("t3_jc_final_pc", {24'd0, bus.romAddr}, 32'h51);
    check("t3_reg_q", {24'd0, reg_q}, 32'h00);

    // pc wrap during an immediate fetch at 0xFE.
    rom_fill();
    rom[0] = 8'h90; rom[1] = 8'hFE; rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h77;
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_operand_addr", {24'd0, bus.romAddr}, 32'hFF);
    check("t4_operand_bus", {24'd0, dbus}, 32'h77);
    @(posedge clk); @(negedge clk);
    check("t4_wrap_pc", {24'd0, bus.romAddr}, 32'h00);
    check("t4_reg_a", {24'd0, reg_a}, 32'h77);

    // Reserved opcode followed by halt.
    rom_fill();
    rom[0] = 8'hA0;
    do_reset();
    @(posedge clk); @(negedge clk);
    check("t5_exec_strobes", {24'd0, strobes()}, 32'h0E);
    @(posedge clk); @(negedge clk);
    check("t5_pc", {24'd0, bus.romAddr}, 32'h01);
    check("t5_not_halted", {31'd0, bus.halted}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("t5_halted", {31'd0, bus.halted}, 32'd1);
    check("t5_halt_pc", {24'd0, bus.romAddr}, 32'h02);

    // Asynchronous reset in the middle of an IMM execute cycle.
    rom_fill();
    rom[0] = 8'h80; rom[1] = 8'h55;
    do_reset();
    @(posedge clk);
    #2;
    check("t6_pre_trigA", {31'd0, bus.triggerA}, 32'd1);
    check("t6_pre_dbus", {24'd0, dbus}, 32'h55);
    resetBar = 1'b0;
    #1;
    check("t6_rst_strobes", {24'd0, strobes()}, 32'h0E);
    check("t6_rst_pc", {24'd0, bus.romAddr}, 32'h00);
    @(negedge clk);
    resetBar = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t6_refetch_ir", {24'd0, bus.ir}, 32'h80);
    check("t6_refetch_pc", {24'd0, bus.romAddr}, 32'h01);
    check("t6_refetch_trigA", {31'd0, bus.triggerA}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Fetch/decode/execute sequencer for the nic8 datapath. It holds the program counter (PC) and instruction register (IR), and reads program bytes from ROM. It generates the per-register trigger and assert-bar strobes that the A/B/X/Q register file consumes, so it sits directly upstream of the register file on the shared 8-bit data bus. Every instruction takes exactly two clocks.

## Interface
Parameters: none.
- clk  in  1  system clock; all state changes on rising edge
- resetBar  in  1  asynchronous, active-low reset
- romAddr  out  8  ROM address; always equals PC
- romData  in  8  ROM byte at romAddr, combinational
- dbus  inout  8  shared data bus; sequencer drives it only for immediates, else high-Z
- triggerA, triggerB, triggerX, triggerQ  out  1 each  active-high one-cycle load strobes to registers
- assertBarA, assertBarX  out  1 each  active-low: register drives dbus
- assertBarAlu  out  1  active-low: ALU drives dbus
- aluSub  out  1  1 = ALU computes A-B, 0 = A+B
- zeroIn, carryIn  in  1 each  ALU flags for the current A/B
- halted  out  1  high in HALT state
- ir  out  8  current instruction register (debug)

## Operation
Instruction byte: src = ir[7:5], dst = ir[4:2], ir[1:0] ignored.

Source codes:
- 0 = A
- 1 = X
- 2 = ALU add
- 3 = ALU sub
- 4 = IMM (next ROM byte)
- 5, 6 = reserved
- 7 = reserved, except src=7 with dst=7 is HALT (0xFC–0xFF)

Destination codes:
- 0 = A
- 1 = B
- 2 = X
- 3 = Q
- 4 = PC (jump)
- 5 = PC if Z
- 6 = PC if C
- 7 = none

States:
- FETCH: ir <= romData; pc <= pc+1. Go to HALT if the byte is a halt encoding, else EXEC. All strobes inactive; dbus high-Z.
- EXEC: assert exactly one source strobe. For IMM, drive dbus = romData and increment pc. Pulse the destination trigger, or load pc from dbus for a taken jump. Return to FETCH.
- HALT: terminal until reset. All strobes inactive; pc and ir frozen.

Rules:
- Flags zf/cf latch zeroIn/carryIn at the end of any EXEC with src 2 or 3. They are otherwise held and reset to 0.
- Conditional jump not taken: pc keeps its sequential value. An IMM operand is still consumed (pc advances past it).
- Jump with IMM source: pc <= operand. The operand-skip increment is overridden by the jump.
- Reserved source: no driver is asserted, no trigger fires, and no pc load occurs (NOP, 2 cycles).
- dst 7: source strobe still asserted (harmless), no trigger fires.
- pc wraps 0xFF -> 0x00, including mid-IMM fetch.
- At most one of assertBarA/assertBarX/assertBarAlu/sequencer-drive is active in any cycle.

## Timing
- Reset (async, while resetBar low):
  - state = FETCH, pc = 0, ir = 0, zf = cf = 0
  - all triggers 0, all assertBars 1, aluSub 0, dbus Z, halted 0
- All outputs are decoded from registered state and ir only (no romData-to-strobe path), except dbus = romData during IMM EXEC.
- A trigger is high for the whole EXEC cycle. The destination register captures dbus at the rising edge that ends EXEC.
- A PC load takes effect at the same edge, so the next FETCH uses the new address.
- Reset asserted mid-EXEC removes strobes immediately (asynchronously); no partial register load is guaranteed.
- First FETCH happens on the first rising edge after resetBar deasserts.

## Structure
- Package control_pkg:
  - state enum {FETCH, EXEC, HALT}
  - SRC_*/DST_* 3-bit code constants
  - IS_HALT predicate
- Sub-module instr_decode (combinational): (state, ir, zf, cf) -> strobes, aluSub, driveImm, pcLoad, pcInc, flagLatch.
- Top holds the pc, ir, flag and state registers, plus the tri-state dbus driver.

## Test plan
- Reset then ROM [0x80 (IMM->A), 0x2A, 0xFC]:
  - A = 0x2A after cycle 2 with triggerA high exactly one cycle
  - halted = 1 from cycle 3; romAddr frozen at 0x03
- ROM [0x84 (IMM->B), 0x05, 0x80 (IMM->A), 0x03, 0x6C (ALU-sub->Q), 0xFC]:
  - aluSub = 1 and assertBarAlu = 0 only in the sub EXEC cycle; Q = 0xFE
  - cf/zf latched from the ALU
- Conditional jump 0x94 (IMM->PC if Z) with operand 0x40:
  - zf = 1: next romAddr = 0x40
  - zf = 0: next romAddr = PC of the opcode + 2
- PC wrap: IMM instruction at 0xFE:
  - operand read at 0xFF; next fetch at 0x00
- Reserved 0xA0 (src 5):
  - two cycles, no strobe, dbus high-Z throughout, pc +1
- Pull resetBar low during an IMM EXEC:
  - triggers drop and dbus goes Z in the same cycle; pc = 0
  - normal fetch from 0x00 after release
